// File: rtl/led_code_pkg.sv
// rtl/led_code_pkg.sv - shared state encoding and default timing for the LED code scheduler
package led_code_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_BIT  = 3'd2,
      ST_SEP  = 3'd3,
      ST_DONE = 3'd4
   } led_state_e;

   localparam int DEF_BIT_T = 20;
   localparam int DEF_T0    = 5;
   localparam int DEF_T1    = 10;
   localparam int DEF_SEP_T = 9;
   localparam int DEF_NSYM  = 4;
   localparam int SYM_W     = 5;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/led_rr_arb.sv
// rtl/led_rr_arb.sv - two-way round-robin arbiter with one-hot grant
module led_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic [1:0] owner,
   output logic [1:0] grant
);

   // prio1 set means requester 1 wins a tie
   logic prio1;

   always_ff @(posedge clk) begin
      if (rst) begin
         prio1 <= 1'b0;
      end else if (advance) begin
         prio1 <= owner[0];
      end
   end

   always_comb begin
      grant = req;
      if (&req) begin
         grant = prio1 ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/led_code_sched.sv
// rtl/led_code_sched.sv - arbitrated LED pulse-width code transmitter; LED_SCHED_PARITY_EN adds a parity cell per symbol
module led_code_sched
   import led_code_pkg::*;
#(
   parameter int BIT_T = DEF_BIT_T,
   parameter int T0    = DEF_T0,
   parameter int T1    = DEF_T1,
   parameter int SEP_T = DEF_SEP_T,
   parameter int NSYM  = DEF_NSYM
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [SYM_W*NSYM-1:0] code0,
   input  logic [SYM_W*NSYM-1:0] code1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [1:0]            gnt,
   output logic                  busy,
   output logic                  led
);

   localparam logic [2:0] IDLE = ST_IDLE;
   localparam logic [2:0] LOAD = ST_LOAD;
   localparam logic [2:0] BIT  = ST_BIT;
   localparam logic [2:0] SEP  = ST_SEP;
   localparam logic [2:0] DONE = ST_DONE;

`ifdef LED_SCHED_PARITY_EN
   localparam int CELLS = SYM_W + 1;
`else
   localparam int CELLS = SYM_W;
`endif
   localparam int MSG_W    = SYM_W * NSYM;
   localparam int TICK_MAX = max2(max2(BIT_T, SEP_T), max2(T0, T1));
   localparam int TCW      = $clog2(TICK_MAX + 1);
   localparam int SIW      = $clog2(NSYM + 1);

   logic [2:0]       state;
   logic [1:0]       gnt_q;
   logic [MSG_W-1:0] shreg;
   logic [TCW-1:0]   tick_cnt;
   logic [2:0]       bit_idx;
   logic [SIW-1:0]   sym_idx;
   logic             cur_bit;
   logic             owner_req;
   logic             abort;
   logic             advance;
   logic [1:0]       arb_grant;

   led_rr_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({req1, req0}),
      .advance (advance),
      .owner   (gnt_q),
      .grant   (arb_grant)
   );

`ifdef LED_SCHED_PARITY_EN
   // even parity accumulated over the symbol's data cells, sent as the sixth cell
   logic par;
   assign cur_bit = (bit_idx == 3'(SYM_W)) ? par : shreg[MSG_W-1];
`else
   assign cur_bit = shreg[MSG_W-1];
`endif

   assign owner_req = |(gnt_q & {req1, req0});
   assign abort     = ((state == LOAD) || (state == BIT) || (state == SEP)) && !owner_req;
   assign advance   = (state == DONE) || abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt_q    <= 2'b00;
         shreg    <= '0;
         tick_cnt <= '0;
         bit_idx  <= '0;
         sym_idx  <= '0;
`ifdef LED_SCHED_PARITY_EN
         par      <= 1'b0;
`endif
      end else if (abort) begin
         state <= IDLE;
         gnt_q <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt_q <= arb_grant;
                  state <= LOAD;
               end
            end
            LOAD: begin
               shreg    <= gnt_q[1] ? code1 : code0;
               tick_cnt <= '0;
               bit_idx  <= '0;
               sym_idx  <= '0;
`ifdef LED_SCHED_PARITY_EN
               par      <= 1'b0;
`endif
               state    <= BIT;
            end
            BIT: begin
               if (tick) begin
                  if (tick_cnt == TCW'(BIT_T - 1)) begin
                     tick_cnt <= '0;
                     if (bit_idx < 3'(SYM_W)) begin
                        shreg <= {shreg[MSG_W-2:0], 1'b0};
`ifdef LED_SCHED_PARITY_EN
                        par   <= par ^ cur_bit;
`endif
                     end
                     if (bit_idx == 3'(CELLS - 1)) begin
                        bit_idx <= '0;
`ifdef LED_SCHED_PARITY_EN
                        par     <= 1'b0;
`endif
                        state   <= SEP;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            SEP: begin
               if (tick) begin
                  if (tick_cnt == TCW'(SEP_T - 1)) begin
                     tick_cnt <= '0;
                     if (sym_idx == SIW'(NSYM - 1)) begin
                        state <= DONE;
                     end else begin
                        sym_idx <= sym_idx + 1'b1;
                        state   <= BIT;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               gnt_q <= 2'b00;
               state <= IDLE;
            end
            default: begin
               gnt_q <= 2'b00;
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      led = 1'b0;
      case (state)
         BIT:     led = (tick_cnt < (cur_bit ? TCW'(T1) : TCW'(T0)));
         SEP:     led = ~tick_cnt[0];
         default: led = 1'b0;
      endcase
   end

   assign busy = (state != IDLE);
   assign gnt  = gnt_q;
   assign ack0 = (state == DONE) && gnt_q[0];
   assign ack1 = (state == DONE) && gnt_q[1];

endmodule

// File: tb/tb_led_code_sched.sv
// tb/tb_led_code_sched.sv - directed bench for led_code_sched
module tb_led_code_sched;

   localparam int BIT_T = 20;
   localparam int T0    = 5;
   localparam int T1    = 10;
   localparam int SEP_T = 9;
   localparam int NSYM  = 4;
`ifdef LED_SCHED_PARITY_EN
   localparam int NB = 6;
`else
   localparam int NB = 5;
`endif
   localparam int CELL_CLKS = NB * BIT_T;
   localparam int SYM_CLKS  = CELL_CLKS + SEP_T;
   localparam int MSG_TICKS = NSYM * SYM_CLKS;

   logic        clk  = 1'b0;
   logic        tick = 1'b0;
   logic        rst;
   logic        req0;
   logic        req1;
   logic [19:0] code0;
   logic [19:0] code1;
   logic        ack0;
   logic        ack1;
   logic [1:0]  gnt;
   logic        busy;
   logic        led;

   int checks = 0;
   int errors = 0;
   int tick_per = 1;
   int tick_ph = 0;
   int ack_at;
   logic       ledv [0:4095];
   logic [1:0] gntv [0:4095];

   led_code_sched #(.BIT_T(BIT_T), .T0(T0), .T1(T1), .SEP_T(SEP_T), .NSYM(NSYM)) dut (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .req0  (req0),
      .req1  (req1),
      .code0 (code0),
      .code1 (code1),
      .ack0  (ack0),
      .ack1  (ack1),
      .gnt   (gnt),
      .busy  (busy),
      .led   (led)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tick_ph + 1 >= tick_per) begin
         tick_ph = 0;
         tick = 1'b1;
      end else begin
         tick_ph = tick_ph + 1;
         tick = 1'b0;
      end
   end

   function automatic logic [19:0] vec(input int s, input int n);
      logic [19:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v = {v[18:0], ledv[s + i]};
      return v;
   endfunction

   // samples one clock per iteration; drops the served request on its ack and returns one clock later
   task automatic capture(input int maxc, input bit use1);
      ack_at = 0;
      for (int k = 1; k <= maxc; k++) begin
         @(negedge clk);
         ledv[k] = led;
         gntv[k] = gnt;
         if (ack_at != 0) break;
         if (use1 ? ack1 : ack0) begin
            ack_at = k;
            if (use1) req1 = 1'b0; else req0 = 1'b0;
         end
      end
   endtask

   task automatic do_reset;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; tick_per = 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; req0 = 1'b1; req1 = 1'b1; code0 = '0; code1 = '0;
      repeat (3) @(negedge clk);
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", led); end
      checks++; if ({ack1, ack0} !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", {ack1, ack0}); end
      req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_msg;
      tick_per = 1; code0 = 20'h00000; req0 = 1'b1;
      capture(700, 1'b0);
      checks++; if (ack_at !== MSG_TICKS + 2) begin errors++; $display("FAIL zero_ack_time got %0d want %0d", ack_at, MSG_TICKS + 2); end
      checks++; if (gntv[1] !== 2'b01) begin errors++; $display("FAIL zero_gnt got %b want 01", gntv[1]); end
      checks++; if (vec(2, 20) !== 20'hF8000) begin errors++; $display("FAIL zero_cell0 got %h want f8000", vec(2, 20)); end
      checks++; if (vec(2 + SYM_CLKS + 3 * BIT_T, 20) !== 20'hF8000) begin errors++; $display("FAIL zero_cell_s1b3 got %h want f8000", vec(2 + SYM_CLKS + 3 * BIT_T, 20)); end
      checks++; if (vec(2 + CELL_CLKS, 9) !== 20'h00155) begin errors++; $display("FAIL zero_sep0 got %h want 00155", vec(2 + CELL_CLKS, 9)); end
      checks++; if (vec(2 + 3 * SYM_CLKS + CELL_CLKS, 9) !== 20'h00155) begin errors++; $display("FAIL zero_sep3 got %h want 00155", vec(2 + 3 * SYM_CLKS + CELL_CLKS, 9)); end
      checks++; if ({ack0, gnt, busy} !== 4'b0000) begin errors++; $display("FAIL zero_after_ack got %b want 0000", {ack0, gnt, busy}); end
   endtask

   task automatic test_rr;
      do_reset();
      code0 = 20'h12345; code1 = 20'hABCDE; req0 = 1'b1; req1 = 1'b1;
      capture(700, 1'b0);
      checks++; if (gntv[1] !== 2'b01) begin errors++; $display("FAIL rr_first_gnt got %b want 01", gntv[1]); end
      checks++; if (ack_at !== MSG_TICKS + 2) begin errors++; $display("FAIL rr_ack0_time got %0d want %0d", ack_at, MSG_TICKS + 2); end
      @(negedge clk);
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rr_second_gnt got %b want 10", gnt); end
      capture(700, 1'b1);
      checks++; if (ack_at !== MSG_TICKS + 1) begin errors++; $display("FAIL rr_ack1_time got %0d want %0d", ack_at, MSG_TICKS + 1); end
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rr_third_gnt got %b want 01", gnt); end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rr_drop_in_load got %b want 00", gnt); end
   endtask

   task automatic test_ones_slow_tick;
      int runs [0:63];
      int nruns;
      int cur;
      do_reset();
      tick_per = 4; code0 = 20'hFFFFF; req0 = 1'b1;
      capture(4000, 1'b0);
      nruns = 0; cur = 0;
      for (int k = 1; k <= ack_at; k++) begin
         if (ledv[k] === 1'b1) cur++;
         else if (cur != 0) begin
            if (nruns < 64) runs[nruns] = cur;
            nruns++; cur = 0;
         end
      end
      checks++; if (ack_at == 0) begin errors++; $display("FAIL slow_ack got none want pulse"); end
      checks++; if (runs[1] !== 40) begin errors++; $display("FAIL slow_cell1_high got %0d want 40", runs[1]); end
      checks++; if (runs[NB - 1] !== 40) begin errors++; $display("FAIL slow_last_cell_high got %0d want 40", runs[NB - 1]); end
      checks++; if (runs[NB] !== 4) begin errors++; $display("FAIL slow_sep_high got %0d want 4", runs[NB]); end
      checks++; if (nruns !== NSYM * (NB + 5) - (NSYM - 1)) begin errors++; $display("FAIL slow_runs got %0d want %0d", nruns, NSYM * (NB + 5) - (NSYM - 1)); end
      tick_per = 1;
   endtask

   task automatic test_abort;
      bit saw_ack;
      int d;
      do_reset();
      code0 = 20'h0F0F0; req0 = 1'b1; req1 = 1'b1; saw_ack = 1'b0;
      d = 2 + 2 * SYM_CLKS + 2 * BIT_T + 3;
      for (int k = 1; k <= d; k++) begin
         @(negedge clk);
         if (ack0) saw_ack = 1'b1;
      end
      checks++; if ({gnt, led} !== 3'b011) begin errors++; $display("FAIL abort_before got %b want 011", {gnt, led}); end
      req0 = 1'b0;
      @(negedge clk);
      if (ack0) saw_ack = 1'b1;
      checks++; if ({gnt, led, busy} !== 4'b0000) begin errors++; $display("FAIL abort_after got %b want 0000", {gnt, led, busy}); end
      @(negedge clk);
      if (ack0) saw_ack = 1'b1;
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL abort_next_owner got %b want 10", gnt); end
      checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack got %b want 0", saw_ack); end
      req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      do_reset();
      code0 = 20'hA5A5A; req0 = 1'b1;
      repeat (2 + CELL_CLKS + 4) @(negedge clk);
      checks++; if ({busy, led} !== 2'b11) begin errors++; $display("FAIL rstmid_in_sep got %b want 11", {busy, led}); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({led, gnt, busy, ack0, ack1} !== 6'b000000) begin errors++; $display("FAIL rstmid_outputs got %b want 000000", {led, gnt, busy, ack0, ack1}); end
      rst = 1'b0;
      capture(700, 1'b0);
      checks++; if (ack_at !== MSG_TICKS + 2) begin errors++; $display("FAIL rstmid_ack_time got %0d want %0d", ack_at, MSG_TICKS + 2); end
      checks++; if (vec(2, 20) !== 20'hFFC00) begin errors++; $display("FAIL rstmid_cell0 got %h want ffc00", vec(2, 20)); end
   endtask

`ifdef LED_SCHED_PARITY_EN
   task automatic test_parity;
      do_reset();
      code0 = {5'b10110, 15'b0}; req0 = 1'b1;
      capture(700, 1'b0);
      checks++; if (vec(2 + 5 * BIT_T, 20) !== 20'hFFC00) begin errors++; $display("FAIL parity_cell got %h want ffc00", vec(2 + 5 * BIT_T, 20)); end
      checks++; if (ack_at !== 518) begin errors++; $display("FAIL parity_ack_time got %0d want 518", ack_at); end
   endtask
`endif

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; code0 = '0; code1 = '0;
      @(negedge clk);
      test_reset();
      test_zero_msg();
      test_rr();
      test_ones_slow_tick();
      test_abort();
      test_reset_mid();
`ifdef LED_SCHED_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_code_sched.md
LED_CODE_SCHED -- requirements
Module: led_code_sched

Interface
REQ-001 Parameter BIT_T, default 20, ticks per bit cell.
REQ-002 Parameter T0, default 5, LED-high ticks for a 0 bit.
REQ-003 Parameter T1, default 10, LED-high ticks for a 1 bit.
REQ-004 Parameter SEP_T, default 9, ticks in the inter-symbol separator.
REQ-005 Parameter NSYM, default 4, 5-bit symbols per message.
REQ-006 Port clk, input, 1, sole clock; reset is synchronous and active-high.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port tick, input, 1, one-clk timing strobe; all LED timing advances only on cycles with tick=1.
REQ-009 Ports req0/req1, input, 1 each, requester wants the LED line; held until its ack or until abandoned.
REQ-010 Ports code0/code1, input, 5*NSYM each, message, symbol 0 in MSBs; stable while req high.
REQ-011 Ports ack0/ack1, output, 1 each, one-clk pulse on message completion.
REQ-012 Port gnt, output, 2, one-hot current owner; 0 when idle.
REQ-013 Port busy, output, 1, high in any state except IDLE.
REQ-014 Port led, output, 1, encoded LED drive.

Function
REQ-015 FSM states IDLE, LOAD, BIT, SEP, DONE.
REQ-016 IDLE: led=0; any req high -> arbitrate that cycle, register gnt, go LOAD.
REQ-017 Arbitration: round-robin; both requesting -> requester not served last wins; pointer after reset favours req0.
REQ-018 LOAD (one clk): latch owner code into shift register; zero bit index, symbol index, tick_cnt; go BIT.
REQ-019 BIT: led=1 while tick_cnt < (bit ? T1 : T0), else 0; tick_cnt increments on tick; at tick_cnt=BIT_T-1 with tick, next bit, tick_cnt=0.
REQ-020 Bits sent MSB-first within each symbol; after the last bit cell of a symbol go SEP.
REQ-021 SEP: led=~tick_cnt[0] (1,0,1,...) for SEP_T ticks; then next symbol -> BIT, or last symbol -> DONE.
REQ-022 DONE (one clk): pulse ack of owner, update RR pointer, clear gnt, led=0, go IDLE.
REQ-023 Message length = NSYM*(5*BIT_T+SEP_T) ticks (436 at defaults), excluding LOAD/DONE clocks.
REQ-024 Owner drops req in LOAD/BIT/SEP: next clk led=0, gnt=0, no ack, pointer advances past owner, go IDLE.
REQ-025 Non-owner req ignored until IDLE; served next if still high.
REQ-026 tick during LOAD or DONE has no effect; codeN changes after LOAD have no effect.
REQ-027 Counters sized for parameter maxima; no wrap within a legal message.

Reset
REQ-028 rst at any clk edge, including mid-message: state=IDLE, led=0, gnt=0, ack0=ack1=0, busy=0, counters 0, pointer favours req0.
REQ-029 rst overrides tick, req and every transition in the same cycle.

Configuration
REQ-030 LED_SCHED_PARITY_EN defined: each symbol gets a sixth bit cell, even parity of its 5 bits, before SEP; length becomes NSYM*(6*BIT_T+SEP_T).
REQ-031 LED_SCHED_PARITY_EN undefined: exactly 5 bit cells per symbol; no parity logic.

Structure
REQ-032 Package led_code_pkg: FSM state enum; default BIT_T, T0, T1, SEP_T, NSYM constants.
REQ-033 Sub-module led_rr_arb: 2-way round-robin arbiter (req, advance, one-hot grant); everything else in led_code_sched.

Verification
REQ-034 tick every clk, req0=1, code0=0x00000 -> per bit led high 5 ticks/low 15; 9-tick separator 1,0,...,1; ack0 pulse 438 clks after req0.
REQ-035 req0 and req1 rise same cycle after reset -> gnt=01, req1 served after ack0; next simultaneous pair -> gnt=01 again.
REQ-036 code0=0xFFFFF, tick every 4th clk -> led high 10 ticks (40 clks) per bit cell.
REQ-037 req0 dropped mid-symbol 2 -> led=0 and gnt=0 next clk, no ack0, pending req1 granted next cycle.
REQ-038 rst asserted during SEP -> all outputs 0 next clk; fresh req0 then sends full message.
REQ-039 LED_SCHED_PARITY_EN defined, symbol 0b10110 -> sixth bit cell is 1 (T1 high); message 516 ticks.
